// File: rtl/freq_div_pkg.sv
// Shared constants and ratio helpers for the programmable frequency divider.
// The legality check is reused by the testbench so both agree on the legal ratio range.
package freq_div_pkg;

    localparam int unsigned MIN_DIV = 2;

    function automatic int unsigned half_ratio(input int unsigned r);
        return r >> 1;
    endfunction

    function automatic bit legal_div(input int unsigned v, input int unsigned width);
        return (v >= MIN_DIV) && (v <= ((32'd1 << width) - 32'd1));
    endfunction

endpackage

// File: rtl/freq_div_neg_stage.sv
// Negedge capture of the posedge counter and phase.
// This is the only falling-edge logic in the divider, so it sits in its own module.
module freq_div_neg_stage import freq_div_pkg::*; #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_pos_count,
    input  logic             i_pos_phase,
    output logic [WIDTH-1:0] o_neg_count,
    output logic             o_neg_phase
);

    logic [WIDTH-1:0] r_neg_count;
    logic             r_neg_phase;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_neg_count <= '0;
            r_neg_phase <= 1'b0;
        end else if (i_en) begin
            r_neg_count <= i_pos_count;
            r_neg_phase <= i_pos_phase;
        end
    end

    assign o_neg_count = r_neg_count;
    assign o_neg_phase = r_neg_phase;

endmodule

// File: rtl/prog_freq_divider.sv
// Programmable integer clock divider, 50% duty for even and odd ratios.
// New ratios are adopted only at the wrap, so an output period is never cut short.
module prog_freq_divider import freq_div_pkg::*; #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic [WIDTH-1:0] pos_count,
    output logic [WIDTH-1:0] neg_count,
    output logic             clk_out,
    output logic [WIDTH-1:0] ratio,
    output logic             period_tick,
    output logic             cfg_err
);

    if (!legal_div(DEFAULT_DIV, WIDTH)) begin : g_bad_default
        $fatal(1, "prog_freq_divider: DEFAULT_DIV %0d outside 2..2^WIDTH-1", DEFAULT_DIV);
    end

    localparam logic [WIDTH-1:0] RESET_RATIO = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(DEFAULT_DIV - 1);

    logic [WIDTH-1:0] r_ratio;
    logic [WIDTH-1:0] r_pending;
    logic [WIDTH-1:0] r_pos_count;
    logic             r_pos_phase;
    logic             r_period_tick;
    logic             r_cfg_err;

    logic [WIDTH-1:0] w_half;
    logic             w_wrap;
    logic             w_load_legal;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_phase;
    logic [WIDTH-1:0] w_neg_count;
    logic             w_neg_phase;

    assign w_half       = WIDTH'(half_ratio(32'(r_ratio)));
    assign w_wrap       = en && (r_pos_count == (r_ratio - WIDTH'(1)));
    assign w_load_legal = legal_div(32'(div_val), WIDTH);
    assign w_next_count = w_wrap ? '0 : (r_pos_count + WIDTH'(1));
    // After a wrap the next count is 0, which is below any legal half ratio.
    assign w_next_phase = (w_next_count < w_half);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ratio       <= RESET_RATIO;
            r_pending     <= RESET_RATIO;
            r_pos_count   <= RESET_COUNT;
            r_pos_phase   <= 1'b0;
            r_period_tick <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            if (en) begin
                r_pos_count <= w_next_count;
                r_pos_phase <= w_next_phase;
            end
            r_period_tick <= w_wrap;

            if (load) begin
                if (w_load_legal) begin
                    r_pending <= div_val;
                    r_cfg_err <= 1'b0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end

            if (w_wrap) begin
                r_ratio <= (load && w_load_legal) ? div_val : r_pending;
            end
        end
    end

    freq_div_neg_stage #(
        .WIDTH (WIDTH)
    ) u_neg_stage (
        .clk         (clk),
        .reset       (reset),
        .i_en        (en),
        .i_pos_count (r_pos_count),
        .i_pos_phase (r_pos_phase),
        .o_neg_count (w_neg_count),
        .o_neg_phase (w_neg_phase)
    );

    // NOTE: the OR is glitch-free because its two inputs come from flops on opposite clock edges.
    assign clk_out     = r_pos_phase | (r_ratio[0] & w_neg_phase);
    assign pos_count   = r_pos_count;
    assign neg_count   = w_neg_count;
    assign ratio       = r_ratio;
    assign period_tick = r_period_tick;
    assign cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed self-checking bench for prog_freq_divider (WIDTH=4, DEFAULT_DIV=3).
// Clock period 10 units, posedges at 10, 20, ...; outputs sampled 1 unit after an edge.
module tb_prog_freq_divider;
    import freq_div_pkg::*;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             reset;
    logic             en;
    logic             load;
    logic [WIDTH-1:0] div_val;
    logic [WIDTH-1:0] pos_count;
    logic [WIDTH-1:0] neg_count;
    logic             clk_out;
    logic [WIDTH-1:0] ratio;
    logic             period_tick;
    logic             cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    prog_freq_divider #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .load        (load),
        .div_val     (div_val),
        .pos_count   (pos_count),
        .neg_count   (neg_count),
        .clk_out     (clk_out),
        .ratio       (ratio),
        .period_tick (period_tick),
        .cfg_err     (cfg_err)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step_neg();
        @(negedge clk);
        #1;
    endtask

    // Poll clk_out once per half clock (always 1 unit after an edge) until it reaches lvl.
    task automatic poll_level(input string tag, input logic lvl, output int unsigned elapsed);
        int unsigned polls = 0;
        while (clk_out !== lvl && polls < 100) begin
            #5;
            polls++;
        end
        elapsed = polls * 5;
        if (clk_out !== lvl) check({tag, "_timeout"}, 32'(clk_out), 32'(lvl));
    endtask

    task automatic measure(input string tag, input int unsigned exp_high, input int unsigned exp_period);
        int unsigned t_skip, t_rise, t_high, t_low;
        @(clk);
        #1;
        poll_level(tag, 1'b0, t_skip);
        poll_level(tag, 1'b1, t_rise);
        poll_level(tag, 1'b0, t_high);
        poll_level(tag, 1'b1, t_low);
        check({tag, "_high"}, t_high, exp_high);
        check({tag, "_period"}, t_high + t_low, exp_period);
    endtask

    task automatic wait_wrap(input string tag);
        int n = 0;
        do begin
            step_pos();
            n++;
        end while (period_tick !== 1'b1 && n < 40);
        if (period_tick !== 1'b1) check({tag, "_wrap_timeout"}, 32'(period_tick), 1);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        div_val = v;
        load    = 1'b1;
        step_pos();
        load    = 1'b0;
    endtask

    initial begin
        int unsigned t_first;
        int n;
        reset   = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        div_val = '0;

        // Reset state
        #2;
        check("rst_pos_count", 32'(pos_count), 2);
        check("rst_neg_count", 32'(neg_count), 0);
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_ratio", 32'(ratio), 3);
        check("rst_tick", 32'(period_tick), 0);
        check("rst_cfg_err", 32'(cfg_err), 0);
        #3;
        reset = 1'b1;

        // Default ratio 3: first enabled posedge wraps and raises clk_out
        step_pos();
        check("d3_c0_count", 32'(pos_count), 0);
        check("d3_c0_clk", 32'(clk_out), 1);
        check("d3_c0_tick", 32'(period_tick), 1);
        step_pos();
        check("d3_c1_count", 32'(pos_count), 1);
        check("d3_c1_tick", 32'(period_tick), 0);
        check("d3_c1_clk", 32'(clk_out), 1);
        step_neg();
        check("d3_neg1", 32'(neg_count), 1);
        check("d3_c1n_clk", 32'(clk_out), 0);
        step_pos();
        check("d3_c2_count", 32'(pos_count), 2);
        measure("d3", 15, 30);

        // Even ratio 4
        do_load(4'd4);
        wait_wrap("d4");
        check("d4_ratio", 32'(ratio), 4);
        check("d4_cfg_err", 32'(cfg_err), 0);
        poll_level("d4_first", 1'b0, t_first);
        check("d4_first_high", t_first, 20);
        check("d4_count_at_fall", 32'(pos_count), 2);
        step_neg();
        check("d4_neg_lag_a", 32'(neg_count), 2);
        step_pos();
        check("d4_pos_next", 32'(pos_count), 3);
        check("d4_neg_lag_b", 32'(neg_count), 2);
        check("d4_low", 32'(clk_out), 0);
        measure("d4", 20, 40);

        // Odd maximum ratio 15, including the switch-over period
        do_load(4'd15);
        wait_wrap("d15");
        check("d15_ratio", 32'(ratio), 15);
        poll_level("d15_first", 1'b0, t_first);
        check("d15_first_high", t_first, 75);
        measure("d15", 75, 150);

        // Illegal loads keep the ratio and set the sticky error
        do_load(4'd1);
        check("ill1_cfg_err", 32'(cfg_err), 1);
        check("ill1_ratio", 32'(ratio), 15);
        do_load(4'd0);
        check("ill0_cfg_err", 32'(cfg_err), 1);
        check("ill0_ratio", 32'(ratio), 15);
        do_load(4'd5);
        check("leg5_cfg_err", 32'(cfg_err), 0);
        wait_wrap("d5");
        check("d5_ratio", 32'(ratio), 5);
        measure("d5", 25, 50);

        // Load of 2 exactly on the wrap edge takes effect on that edge
        n = 0;
        do begin
            step_pos();
            n++;
        end while (pos_count !== 4'd4 && n < 20);
        check("wrapload_sync", 32'(pos_count), 4);
        div_val = 4'd2;
        load    = 1'b1;
        step_pos();
        load    = 1'b0;
        check("wrapload_ratio", 32'(ratio), 2);
        check("wrapload_count", 32'(pos_count), 0);
        check("wrapload_clk", 32'(clk_out), 1);
        check("wrapload_tick", 32'(period_tick), 1);
        step_neg();
        check("d2_neg_clk", 32'(clk_out), 1);
        step_pos();
        check("d2_c1_count", 32'(pos_count), 1);
        check("d2_c1_clk", 32'(clk_out), 0);
        step_pos();
        check("d2_c0_clk", 32'(clk_out), 1);
        measure("d2", 10, 20);

        // Freeze mid-high for three cycles; an illegal load is still taken while frozen
        do_load(4'd6);
        wait_wrap("d6");
        check("d6_ratio", 32'(ratio), 6);
        step_pos();
        check("d6_c1_count", 32'(pos_count), 1);
        en = 1'b0;
        do_load(4'd0);
        step_pos();
        step_pos();
        check("frz_count", 32'(pos_count), 1);
        check("frz_neg_count", 32'(neg_count), 0);
        check("frz_clk", 32'(clk_out), 1);
        check("frz_tick", 32'(period_tick), 0);
        check("frz_cfg_err", 32'(cfg_err), 1);
        en = 1'b1;
        step_pos();
        check("res_c2_count", 32'(pos_count), 2);
        check("res_c2_clk", 32'(clk_out), 1);
        step_neg();
        check("res_neg_count", 32'(neg_count), 2);
        step_pos();
        check("res_c3_count", 32'(pos_count), 3);
        check("res_c3_clk", 32'(clk_out), 0);
        step_pos();
        step_pos();
        check("res_c5_count", 32'(pos_count), 5);
        step_pos();
        check("res_wrap_count", 32'(pos_count), 0);
        check("res_wrap_tick", 32'(period_tick), 1);
        check("res_wrap_clk", 32'(clk_out), 1);

        // Asynchronous reset mid-period, away from any clock edge
        step_pos();
        #1;
        reset = 1'b0;
        #1;
        check("arst_pos_count", 32'(pos_count), 2);
        check("arst_neg_count", 32'(neg_count), 0);
        check("arst_clk", 32'(clk_out), 0);
        check("arst_cfg_err", 32'(cfg_err), 0);
        check("arst_ratio", 32'(ratio), 3);
        check("arst_tick", 32'(period_tick), 0);
        reset = 1'b1;
        step_pos();
        check("post_rst_count", 32'(pos_count), 0);
        check("post_rst_clk", 32'(clk_out), 1);
        measure("d3_again", 15, 30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
